// File: rtl/msrv_32_pkg.sv
// Shared types and constants for the MSRV32 PC-generation slice.
package msrv_32_pkg;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        MISALIGN = 2'd2
    } pc_state_t;

    localparam logic [31:0] PC_INC        = 32'd4;
    localparam logic [31:0] DEF_BOOT_ADDR = 32'h0000_0000;

endpackage

// File: rtl/msrv_32_pc_mux.sv
// Combinational next-PC priority selector.
module msrv_32_pc_mux
    import msrv_32_pkg::*;
(
    input  logic        boot_i,
    input  logic        trap_i,
    input  logic        misalign_i,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] boot_addr_i,
    input  logic [31:0] trap_addr_i,
    input  logic [31:0] tgt_i,
    input  logic [31:0] pc_i,
    output logic [31:0] next_pc_o
);

    always_comb begin
        next_pc_o = pc_i + PC_INC;
        if (boot_i) begin
            next_pc_o = boot_addr_i;
        end else if (trap_i) begin
            next_pc_o = {trap_addr_i[31:2], 2'b00};
        end else if (misalign_i || stall_i) begin
            next_pc_o = pc_i;
        end else if (branch_i) begin
            // A misaligned target never leaves the core; the PC parks.
            next_pc_o = tgt_i[1] ? pc_i : tgt_i;
        end
    end

endmodule

// File: rtl/msrv_32_pc_gen.sv
// PC register, fetch address and redirect qualifiers for MSRV32.
module msrv_32_pc_gen
    import msrv_32_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR = DEF_BOOT_ADDR
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_n_in,
    input  logic [31:0] iadder_in,
    input  logic        branch_taken_in,
    input  logic        trap_taken_in,
    input  logic [31:0] trap_addr_in,
    input  logic        stall_in,
    output logic [31:0] i_addr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus_4_out,
    output logic        valid_out,
    output logic        flush_out,
    output logic        misaligned_out,
    output logic [31:0] misaligned_addr_out
);

    pc_state_t   state_q, state_d;
    logic [31:0] pc_q, next_pc;
    logic        valid_q, flush_q, mis_q;
    logic [31:0] mis_addr_q;
    logic [31:0] tgt;
    logic        in_boot, in_mis;
    logic        trap_redir, br_live, br_ok, br_bad;
    logic        unused_bits;

    assign tgt         = {iadder_in[31:1], 1'b0};
    assign unused_bits = ^{iadder_in[0], trap_addr_in[1:0]};

    // Holding reset makes the fetch address show BOOT_ADDR immediately.
    assign in_boot = !ms_riscv32_mp_rst_n_in || (state_q == BOOT);
    assign in_mis  = (state_q == MISALIGN);

    assign trap_redir = trap_taken_in && !in_boot;
    assign br_live    = branch_taken_in && !in_boot && !in_mis
                        && !stall_in && !trap_taken_in;
    assign br_ok      = br_live && !tgt[1];
    assign br_bad     = br_live && tgt[1];

    msrv_32_pc_mux u_mux (
        .boot_i      (in_boot),
        .trap_i      (trap_taken_in),
        .misalign_i  (in_mis),
        .stall_i     (stall_in),
        .branch_i    (branch_taken_in),
        .boot_addr_i (BOOT_ADDR),
        .trap_addr_i (trap_addr_in),
        .tgt_i       (tgt),
        .pc_i        (pc_q),
        .next_pc_o   (next_pc)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:     state_d = RUN;
            RUN:      state_d = br_bad ? MISALIGN : RUN;
            MISALIGN: state_d = trap_taken_in ? RUN : MISALIGN;
            default:  state_d = BOOT;
        endcase
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            state_q    <= BOOT;
            pc_q       <= BOOT_ADDR;
            valid_q    <= 1'b0;
            flush_q    <= 1'b0;
            mis_q      <= 1'b0;
            mis_addr_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= next_pc;
            valid_q <= (state_d == RUN);
            flush_q <= trap_redir || br_ok;
            mis_q   <= (state_d == MISALIGN);
            if (br_bad) begin
                mis_addr_q <= tgt;
            end
        end
    end

    assign i_addr_out          = next_pc;
    assign pc_out              = pc_q;
    assign pc_plus_4_out       = pc_q + PC_INC;
    assign valid_out           = valid_q;
    assign flush_out           = flush_q;
    assign misaligned_out      = mis_q;
    assign misaligned_addr_out = mis_addr_q;

endmodule

// File: tb/tb_msrv_32_pc_gen.sv
// Directed-vector scoreboard bench for msrv_32_pc_gen.
module tb_msrv_32_pc_gen;

    typedef struct {
        logic        rst_n;
        logic        br;
        logic        tr;
        logic        st;
        logic [31:0] iadd;
        logic [31:0] taddr;
        logic [31:0] e_iaddr;
        logic [31:0] e_pc;
        logic        e_valid;
        logic        e_flush;
        logic        e_mis;
        logic [31:0] e_maddr;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] iadder;
    logic        branch;
    logic        trap;
    logic [31:0] trap_addr;
    logic        stall;
    logic [31:0] i_addr;
    logic [31:0] pc;
    logic [31:0] pc_p4;
    logic        valid;
    logic        flush;
    logic        mis;
    logic [31:0] mis_addr;

    vec_t vecs[$];
    vec_t sb[$];
    int   total = 0;
    int   bad   = 0;
    bit   drv_done = 0;

    msrv_32_pc_gen #(.BOOT_ADDR(32'h0000_1000)) dut (
        .ms_riscv32_mp_clk_in   (clk),
        .ms_riscv32_mp_rst_n_in (rst_n),
        .iadder_in              (iadder),
        .branch_taken_in        (branch),
        .trap_taken_in          (trap),
        .trap_addr_in           (trap_addr),
        .stall_in               (stall),
        .i_addr_out             (i_addr),
        .pc_out                 (pc),
        .pc_plus_4_out          (pc_p4),
        .valid_out              (valid),
        .flush_out              (flush),
        .misaligned_out         (mis),
        .misaligned_addr_out    (mis_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL v%0d %s: got %h want %h", idx, name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic b, input logic t,
                       input logic s, input logic [31:0] ia,
                       input logic [31:0] ta, input logic [31:0] eia,
                       input logic [31:0] epc, input logic ev,
                       input logic ef, input logic em,
                       input logic [31:0] ema);
        vec_t v;
        v.rst_n = r; v.br = b; v.tr = t; v.st = s;
        v.iadd = ia; v.taddr = ta;
        v.e_iaddr = eia; v.e_pc = epc; v.e_valid = ev;
        v.e_flush = ef; v.e_mis = em; v.e_maddr = ema;
        vecs.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0; branch = 1'b0; trap = 1'b0; stall = 1'b0;
        iadder = 32'h0; trap_addr = 32'h0;

        //  rst br tr st  iadder        trap_addr     i_addr        pc            v  f  m  mis_addr
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h1000,     32'h1000,     0, 0, 0, 32'h0);
        add(0, 0, 0, 0, 32'h0,        32'h0,        32'h1000,     32'h1000,     0, 0, 0, 32'h0);
        add(1, 0, 0, 0, 32'h0,        32'h0,        32'h1000,     32'h1000,     1, 0, 0, 32'h0);
        add(1, 0, 0, 0, 32'h0,        32'h0,        32'h1004,     32'h1004,     1, 0, 0, 32'h0);
        add(1, 0, 0, 0, 32'h0,        32'h0,        32'h1008,     32'h1008,     1, 0, 0, 32'h0);
        add(1, 1, 0, 0, 32'h2000,     32'h0,        32'h2000,     32'h2000,     1, 1, 0, 32'h0);
        add(1, 1, 0, 0, 32'h3001,     32'h0,        32'h3000,     32'h3000,     1, 1, 0, 32'h0);
        add(1, 0, 0, 0, 32'h0,        32'h0,        32'h3004,     32'h3004,     1, 0, 0, 32'h0);
        add(1, 1, 0, 0, 32'h3002,     32'h0,        32'h3004,     32'h3004,     0, 0, 1, 32'h3002);
        add(1, 1, 0, 1, 32'h5000,     32'h0,        32'h3004,     32'h3004,     0, 0, 1, 32'h3002);
        add(1, 0, 1, 0, 32'h0,        32'h0103,     32'h0100,     32'h0100,     1, 1, 0, 32'h3002);
        add(1, 1, 1, 1, 32'h4000,     32'h0080,     32'h0080,     32'h0080,     1, 1, 0, 32'h3002);
        add(1, 1, 0, 1, 32'h4000,     32'h0,        32'h0080,     32'h0080,     1, 0, 0, 32'h3002);
        add(1, 0, 0, 1, 32'h0,        32'h0,        32'h0080,     32'h0080,     1, 0, 0, 32'h3002);
        add(1, 0, 1, 0, 32'h0,        32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFFC, 1, 1, 0, 32'h3002);
        add(1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        1, 0, 0, 32'h3002);
        add(1, 1, 0, 0, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h0,        0, 0, 1, 32'hFFFFFFFE);
        add(0, 0, 1, 0, 32'h0,        32'h0200,     32'h1000,     32'h1000,     0, 0, 0, 32'h0);
        add(1, 0, 0, 0, 32'h0,        32'h0,        32'h1000,     32'h1000,     1, 0, 0, 32'h0);
        add(1, 0, 0, 0, 32'h0,        32'h0,        32'h1004,     32'h1004,     1, 0, 0, 32'h0);

        fork
            begin : driver
                foreach (vecs[i]) begin
                    @(negedge clk);
                    rst_n = vecs[i].rst_n;
                    branch = vecs[i].br;
                    trap = vecs[i].tr;
                    stall = vecs[i].st;
                    iadder = vecs[i].iadd;
                    trap_addr = vecs[i].taddr;
                    #1;
                    sb.push_back(vecs[i]);
                end
                @(negedge clk);
                drv_done = 1;
            end
            begin : monitor
                vec_t e;
                int   idx = 0;
                int   guard;
                bit   stop = 0;
                while (!stop) begin
                    guard = 0;
                    while (sb.size() == 0 && !drv_done && guard < 200) begin
                        #1;
                        guard++;
                    end
                    if (sb.size() == 0) begin
                        if (!drv_done) begin
                            total++;
                            bad++;
                            $display("FAIL timeout: no vector after %0d steps", guard);
                        end
                        stop = 1;
                    end else begin
                        e = sb.pop_front();
                        chk("i_addr", idx, i_addr, e.e_iaddr);
                        @(posedge clk);
                        #1;
                        chk("pc", idx, pc, e.e_pc);
                        chk("pc_plus_4", idx, pc_p4, e.e_pc + 32'd4);
                        chk("valid", idx, {31'b0, valid}, {31'b0, e.e_valid});
                        chk("flush", idx, {31'b0, flush}, {31'b0, e.e_flush});
                        chk("misaligned", idx, {31'b0, mis}, {31'b0, e.e_mis});
                        chk("mis_addr", idx, mis_addr, e.e_maddr);
                        idx++;
                    end
                end
            end
        join

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/msrv_32_pc_gen.md
# msrv_32_pc_gen

Program-counter generation stage of the MSRV32 core, directly downstream of `msrv_32_imm_adder`. It consumes the branch/jump target on `iadder_in` and selects the next PC from four sources: boot address, trap vector, branch target, or sequential PC+4. It holds the PC register, drives the instruction-memory address, flags misaligned branch targets, and emits flush/valid qualifiers to the fetch/decode boundary.

## Interface
- `BOOT_ADDR`, default 32'h0000_0000, first PC fetched after reset; must be 4-byte aligned.
- `ms_riscv32_mp_clk_in`  in  1  core clock; all state updates on rising edge.
- `ms_riscv32_mp_rst_n_in`  in  1  synchronous, active-low reset.
- `iadder_in`  in  32  branch/jump target from `msrv_32_imm_adder`.
- `branch_taken_in`  in  1  taken branch, JAL or JALR this cycle.
- `trap_taken_in`  in  1  trap entry or MRET from the CSR unit.
- `trap_addr_in`  in  32  mtvec or mepc value for the trap redirect.
- `stall_in`  in  1  hold the PC.
- `i_addr_out`  out  32  next PC to synchronous instruction memory (combinational).
- `pc_out`  out  32  registered PC of the instruction returning from memory.
- `pc_plus_4_out`  out  32  `pc_out + 4` (link value).
- `valid_out`  out  1  `pc_out` belongs to an executable instruction.
- `flush_out`  out  1  one-cycle pulse: squash the instruction in decode.
- `misaligned_out`  out  1  instruction-address-misaligned exception pending.
- `misaligned_addr_out`  out  32  offending target, for mtval.

## Operation
- FSM states: BOOT, RUN, MISALIGN.
- Target: `tgt = {iadder_in[31:1],1'b0}`; bit 0 always cleared (JALR rule). `tgt[1]=1` marks the target misaligned.
- `next_pc` selection, highest priority first:
  - BOOT: `BOOT_ADDR`.
  - `trap_taken_in`: `{trap_addr_in[31:2],2'b00}`.
  - MISALIGN: `pc_out`.
  - `stall_in`: `pc_out`.
  - `branch_taken_in` with aligned target: `tgt`.
  - `branch_taken_in` with misaligned target: `pc_out`.
  - Otherwise: `pc_out + 4`.
- `i_addr_out = next_pc`; `pc_out <= next_pc` on every non-reset edge.
- Transitions:
  - Reset: go to BOOT.
  - BOOT: go to RUN unconditionally after one cycle; stall and branch are ignored.
  - RUN: a misaligned taken branch without a trap goes to MISALIGN. Otherwise stay in RUN.
  - MISALIGN: `trap_taken_in` goes to RUN. Otherwise stay, ignoring branch and stall.
- On entry to MISALIGN, `misaligned_addr_out <= tgt`; the value holds until the next entry or reset.
- `misaligned_out` is registered, equal to (state == MISALIGN).
- `valid_out <= (next_state == RUN)`.
- `flush_out <= trap redirect OR accepted aligned branch`.
- Arithmetic is 32-bit modulo: PC+4 from 32'hFFFF_FFFC wraps to 0 with no flag.

## Timing
- Reset values:
  - `pc_out = BOOT_ADDR`, `pc_plus_4_out = BOOT_ADDR+4`.
  - `i_addr_out = BOOT_ADDR`.
  - `valid_out = 0`, `flush_out = 0`, `misaligned_out = 0`, `misaligned_addr_out = 0`.
- Reset mid-operation overrides every input in that cycle, including a pending trap or MISALIGN.
- Redirect latency: target appears on `i_addr_out` in the same cycle (combinational) and on `pc_out` after one edge. `flush_out` is high for exactly the cycle following the redirect edge.
- First valid fetch: `valid_out=1` one edge after reset release, with `pc_out=BOOT_ADDR`.
- Simultaneous events:
  - Trap with branch: trap wins, one flush.
  - Trap with stall: trap wins.
  - Stall with branch: stall wins; upstream re-presents the branch.
  - Back-to-back redirects each produce a flush pulse, so `flush_out` may stay high.
- `stall_in` holds `valid_out` and `pc_out` unchanged and never raises `flush_out`.

## Structure
- Shared package `msrv_32_pkg` holds:
  - State enum `pc_state_t` (BOOT, RUN, MISALIGN).
  - `PC_INC = 32'd4`.
  - Default `BOOT_ADDR` constant.
- Natural sub-module: `msrv_32_pc_mux`, the purely combinational next-PC priority selector. FSM and registers stay in `msrv_32_pc_gen`.

## Test plan
- Reset then release, `BOOT_ADDR`=0x1000:
  - In reset: `i_addr_out`=0x1000.
  - First edge after release: `pc_out`=0x1000, `valid_out`=1.
  - Subsequent edges: `pc_out` = 0x1004, then 0x1008.
- At `pc_out`=0x2000, branch with `iadder_in`=0x3001: `i_addr_out`=0x3000 same cycle; next edge `pc_out`=0x3000, `flush_out`=1 for one cycle.
- Branch with `iadder_in`=0x3002:
  - `pc_out` holds; `misaligned_out`=1, `misaligned_addr_out`=0x3002, `valid_out`=0.
  - Then `trap_taken_in` with `trap_addr_in`=0x0103 gives `pc_out`=0x0100, state RUN, `flush_out`=1.
- Same cycle `stall_in`=1, `branch_taken_in`=1, `trap_taken_in`=1, `trap_addr_in`=0x80: `pc_out`=0x80; with trap low instead, `pc_out` holds and `flush_out`=0.
- `pc_out`=0xFFFF_FFFC sequential: `pc_plus_4_out`=0, next `pc_out`=0x0000_0000.
- Reset asserted during MISALIGN: next edge `pc_out`=`BOOT_ADDR`, `misaligned_out`=0, `misaligned_addr_out`=0, `valid_out`=0.
